// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the writeback collector.
package cdb_arbiter_pkg;

  // Global core configuration; only XLEN is consumed here.
  typedef struct packed {
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{XLEN: 32};

  // Writeback source map.
  localparam int NUM_WB_SRC = 6;
  localparam int SRC_ALU0   = 0;
  localparam int SRC_ALU1   = 1;
  localparam int SRC_ALU2   = 2;
  localparam int SRC_ALU3   = 3;
  localparam int SRC_MUL    = 4;
  localparam int SRC_LSU    = 5;

  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] val;
  } cdb_entry_t;

  // (base + off) modulo n, for round-robin scan order.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_wb_fifo.sv
// Per-source result FIFO: one push, one pop, synchronous clear.
// The caller never pushes when full nor pops when empty.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 38,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          not_empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Entry storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback collector: buffers results per source and broadcasts up to
// CDB_W of them per cycle on the common data bus, round-robin across sources.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter cfg_t Cfg        = EmptyCfg,
  parameter int   NUM_SRC    = NUM_WB_SRC,
  parameter int   CDB_W      = 4,
  parameter int   TAG_W      = CDB_TAG_W,
  parameter int   DATA_W     = Cfg.XLEN,
  parameter int   FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [NUM_SRC-1:0]             src_valid_i,
  output logic [NUM_SRC-1:0]             src_ready_o,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag_i,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] src_val_i,
  output logic [CDB_W-1:0]               cdb_valid,
  output logic [CDB_W-1:0][TAG_W-1:0]    cdb_tag,
  output logic [CDB_W-1:0][DATA_W-1:0]   cdb_val
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int LW = (CDB_W > 1) ? $clog2(CDB_W) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = TAG_W + DATA_W;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] grant;
  logic [EW-1:0]      head  [NUM_SRC];
  logic [CW-1:0]      count [NUM_SRC];

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      rr_next;
  logic [CDB_W-1:0]   lane_hit;
  logic [PW-1:0]      lane_src [CDB_W];
  int                 sel_n;
  int                 sel_idx;

  // Ready comes only from the registered count: a same-cycle pop does not help.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready_o[i] = (count[i] < CW'(FIFO_DEPTH));
    end
  end

  assign push = src_valid_i & src_ready_o & {NUM_SRC{~flush_i}};
  assign pop  = grant & {NUM_SRC{~flush_i}};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush_i),
      .push      (push[g]),
      .push_data ({src_tag_i[g], src_val_i[g]}),
      .pop       (pop[g]),
      .head      (head[g]),
      .not_empty (not_empty[g]),
      .count     (count[g])
    );
  end

  // Scan from rr_ptr and hand non-empty sources to lanes in scan order.
  always_comb begin
    grant    = '0;
    lane_hit = '0;
    for (int l = 0; l < CDB_W; l++) lane_src[l] = '0;
    rr_next  = rr_ptr;
    sel_n    = 0;
    sel_idx  = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_idx = wrap_idx(int'(rr_ptr), k, NUM_SRC);
      if (not_empty[PW'(sel_idx)] && (sel_n < CDB_W)) begin
        grant[PW'(sel_idx)]  = 1'b1;
        lane_hit[LW'(sel_n)] = 1'b1;
        lane_src[LW'(sel_n)] = PW'(sel_idx);
        rr_next              = PW'(wrap_idx(sel_idx, 1, NUM_SRC));
        sel_n                = sel_n + 1;
      end
    end
  end

  // Lane registers and round-robin pointer; flush only drops lane validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_val   <= '0;
      rr_ptr    <= '0;
    end else if (flush_i) begin
      cdb_valid <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int l = 0; l < CDB_W; l++) begin
        if (lane_hit[l]) begin
          cdb_valid[l]              <= 1'b1;
          {cdb_tag[l], cdb_val[l]}  <= head[lane_src[l]];
        end else begin
          cdb_valid[l] <= 1'b0;
          cdb_tag[l]   <= '0;
          cdb_val[l]   <= '0;
        end
      end
    end
  end

endmodule
